// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op and funct encodings, FSM states and operand helpers.
package mul_div_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIN  = 2'b11
   } md_state_e;

   // Two's-complement negate when neg is set, otherwise pass through.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational step logic for the multiply/divide unit: one shift-add or
// restoring shift-subtract iteration, plus sign fix-up of the final result.
module md_datapath
   import mul_div_unit_pkg::*;
#(
   parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF
) (
   input  logic        is_div,
   input  logic [63:0] acc,
   input  logic [31:0] rem,
   input  logic [31:0] b,
   input  logic        neg_q,
   input  logic        neg_r,
   input  logic        div0,
   output logic [63:0] acc_nxt,
   output logic [31:0] rem_nxt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        go;
   logic [63:0] prod;

   always_comb begin
      sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);
      shifted = {rem, acc[31]};
      diff    = shifted - {1'b0, b};
      // A set top bit means shifted already exceeds any 32-bit divisor.
      go      = shifted[32] | ~diff[32];
      prod    = neg_q ? (~acc + 64'd1) : acc;
      if (is_div) begin
         acc_nxt = {acc[63:32], acc[30:0], go};
         rem_nxt = go ? diff[31:0] : shifted[31:0];
         res_lo  = div0 ? DIV0_Q : mag32(acc[31:0], neg_q);
         res_hi  = mag32(rem, neg_r);
      end else begin
         acc_nxt = {sum, acc[31:1]};
         rem_nxt = rem;
         res_lo  = prod[31:0];
         res_hi  = prod[63:32];
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO state for the EX stage.
// Owns the FSM, iteration counter and the architectural HI/LO registers.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF,
   parameter int unsigned ITER   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

   md_state_e      state;
   logic [CW-1:0]  cnt;
   logic [63:0]    acc;
   logic [31:0]    rem;
   logic [31:0]    b;
   logic           neg_q;
   logic           neg_r;
   logic           div0;
   logic           is_div;

   logic [63:0]    acc_nxt;
   logic [31:0]    rem_nxt;
   logic [31:0]    res_hi;
   logic [31:0]    res_lo;

   logic           sgn_op;
   logic           div_op;
   logic [31:0]    mag_rs;
   logic [31:0]    mag_rt;

   always_comb begin
      sgn_op = (op == MD_MULT) || (op == MD_DIV);
      div_op = (op == MD_DIV)  || (op == MD_DIVU);
      mag_rs = mag32(rs_val, sgn_op & rs_val[31]);
      mag_rt = mag32(rt_val, sgn_op & rt_val[31]);
   end

   md_datapath #(.DIV0_Q(DIV0_Q)) u_dp (
      .is_div  (is_div),
      .acc     (acc),
      .rem     (rem),
      .b       (b),
      .neg_q   (neg_q),
      .neg_r   (neg_r),
      .div0    (div0),
      .acc_nxt (acc_nxt),
      .rem_nxt (rem_nxt),
      .res_hi  (res_hi),
      .res_lo  (res_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         rem    <= '0;
         b      <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         is_div <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start) begin
                  state  <= div_op ? DIV : MUL;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  rem    <= '0;
                  // Multiply shifts the multiplier out of acc[31:0]; divide
                  // shifts the dividend out and quotient bits in.
                  b      <= div_op ? mag_rt : mag_rs;
                  acc    <= {32'd0, div_op ? mag_rs : mag_rt};
                  neg_q  <= sgn_op & (rs_val[31] ^ rt_val[31]);
                  neg_r  <= sgn_op & rs_val[31];
                  div0   <= div_op && (rt_val == 32'd0);
                  is_div <= div_op;
               end
            end
            MUL, DIV: begin
               acc <= acc_nxt;
               rem <= rem_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1)) state <= FIN;
            end
            FIN: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: signed/unsigned multiply and
// divide corner cases, busy/done timing, and start/mthi/reset robustness.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp;
   int n_err;

   mul_div_unit #(.DIV0_Q(32'hFFFF_FFFF), .ITER(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulse start for one cycle; returns at the negedge after the accepting edge
   // with operands scrambled to show they were captured.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = d;
      @(negedge clk);
      start  = 1'b0;
      rs_val = 32'h5A5A_A5A5;
      rt_val = 32'h0000_0000;
   endtask

   // Counts negedges with busy=1 until done is seen, bounded to 100 cycles.
   task automatic wait_done(output int cyc, output logic ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy) cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int   cyc;
      logic ok;
      launch(o, a, d);
      wait_done(cyc, ok);
      check({tag, "_done"}, {31'd0, ok}, 32'd1);
      check({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int   cyc;
      logic ok;
      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = MD_MULT;
      rs_val = '0;
      rt_val = '0;
      mthi   = 1'b0;
      mtlo   = 1'b0;
      wdata  = '0;

      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec("mult_neg2x3",  MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_vec("multu_max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_vec("div_neg7by2",  MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_vec("divu_by0",     MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      run_vec("div_ovf",      MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_vec("divu_1000by7", MD_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142);

      // start + mthi while busy must not disturb the in-flight multiply
      launch(MD_MULTU, 32'h0001_0000, 32'h0000_0010);
      repeat (5) @(negedge clk);
      start  = 1'b1;
      op     = MD_DIV;
      rs_val = 32'd9;
      rt_val = 32'd3;
      mthi   = 1'b1;
      wdata  = 32'h0000_1234;
      @(negedge clk);
      start  = 1'b0;
      mthi   = 1'b0;
      wait_done(cyc, ok);
      check("busy_ign_done", {31'd0, ok}, 32'd1);
      check("busy_ign_hi", hi, 32'h0000_0000);
      check("busy_ign_lo", lo, 32'h0010_0000);
      @(negedge clk);
      check("busy_ign_idle", {31'd0, busy}, 32'd0);

      // async reset at iteration 10 aborts and clears HI/LO
      launch(MD_MULTU, 32'h0000_0003, 32'h0000_0005);
      repeat (10) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);

      // mtlo when idle
      mtlo  = 1'b1;
      wdata = 32'h0000_ABCD;
      @(negedge clk);
      mtlo  = 1'b0;
      check("mtlo_lo", lo, 32'h0000_ABCD);
      check("mtlo_hi", hi, 32'd0);

      // mthi and mtlo together
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h0000_0055;
      @(negedge clk);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      check("mtboth_hi", hi, 32'h0000_0055);
      check("mtboth_lo", lo, 32'h0000_0055);

      // mthi in the same cycle as an accepted start; result overwrites it
      @(negedge clk);
      start  = 1'b1;
      op     = MD_MULT;
      rs_val = 32'h0000_0007;
      rt_val = 32'hFFFF_FFFA;
      mthi   = 1'b1;
      wdata  = 32'h0000_7777;
      @(negedge clk);
      start  = 1'b0;
      mthi   = 1'b0;
      check("mt_start_hi", hi, 32'h0000_7777);
      check("mt_start_busy", {31'd0, busy}, 32'd1);
      wait_done(cyc, ok);
      check("mt_start_done", {31'd0, ok}, 32'd1);
      check("mt_start_res_hi", hi, 32'hFFFF_FFFF);
      check("mt_start_res_lo", lo, 32'hFFFF_FFD6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
